// File: rtl/hdu_pipe_pkg.sv
// Shared CPU pipeline definitions: hazard FSM states and operand forward-select codes.
package hdu_pipe_pkg;

  typedef enum logic {
    StIdle,
    StHold
  } hdu_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Remaining-stall counter width; covers LOAD_LAT-1 for LOAD_LAT up to 4.
  localparam int unsigned HOLD_CNT_W = 2;

endpackage

// File: rtl/hdu_pipe_fwd_sel.sv
// Operand bypass select for one EX source register; the younger EX/MEM result wins.
module fwd_sel
  import hdu_pipe_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter bit          ENABLE = 1'b1
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] exmem_rd_i,
  input  logic             exmem_we_i,
  input  logic [REG_W-1:0] memwb_rd_i,
  input  logic             memwb_we_i,
  output logic [1:0]       sel_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (ENABLE) begin
      if (exmem_hit) begin
        sel_o = FWD_EXMEM;
      end else if (memwb_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hdu_pipe.sv
// Hazard detection unit: operand forwarding selects, load-use / RAW stall FSM, branch flush
// control and saturating stall/flush performance counters.
module hdu_pipe
  import hdu_pipe_pkg::*;
#(
  parameter int unsigned FORWARDING_ON = 1,
  parameter int unsigned REG_W         = 5,
  parameter int unsigned LOAD_LAT      = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] idex_rs1,
  input  logic [REG_W-1:0] idex_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_memRead,
  input  logic             idex_regWrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regWrite,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regWrite,
  input  logic             br_taken,
  output logic [1:0]       forwA,
  output logic [1:0]       forwB,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit FwdEn = (FORWARDING_ON != 0);
  localparam logic [HOLD_CNT_W-1:0] HoldLoad = HOLD_CNT_W'(LOAD_LAT - 1);

  hdu_state_e            state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  fwd_sel #(
    .REG_W  (REG_W),
    .ENABLE (FwdEn)
  ) u_fwd_a (
    .rs_i       (idex_rs1),
    .exmem_rd_i (exmem_rd),
    .exmem_we_i (exmem_regWrite),
    .memwb_rd_i (memwb_rd),
    .memwb_we_i (memwb_regWrite),
    .sel_o      (forwA)
  );

  fwd_sel #(
    .REG_W  (REG_W),
    .ENABLE (FwdEn)
  ) u_fwd_b (
    .rs_i       (idex_rs2),
    .exmem_rd_i (exmem_rd),
    .exmem_we_i (exmem_regWrite),
    .memwb_rd_i (memwb_rd),
    .memwb_we_i (memwb_regWrite),
    .sel_o      (forwB)
  );

  // A producer rd is "used" when it is non-zero and names a source the ID instruction reads.
  logic idex_used, exmem_used, memwb_used;
  logic hit;

  assign idex_used  = (idex_rd != '0) &&
                      ((idex_rd == id_rs1) || (id_use_rs2 && (idex_rd == id_rs2)));
  assign exmem_used = (exmem_rd != '0) &&
                      ((exmem_rd == id_rs1) || (id_use_rs2 && (exmem_rd == id_rs2)));
  assign memwb_used = (memwb_rd != '0) &&
                      ((memwb_rd == id_rs1) || (id_use_rs2 && (memwb_rd == id_rs2)));

  assign hit = FwdEn ? (idex_memRead && idex_used)
                     : ((idex_regWrite && idex_used) || (exmem_regWrite && exmem_used) ||
                        (memwb_regWrite && memwb_used));

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (br_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_d    = StIdle;
      hold_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = StHold;
              hold_d  = HoldLoad;
            end
          end
        end
        StHold: begin
          stall      = 1'b1;
          flush_idex = 1'b1;
          hold_d     = hold_q - 1'b1;
          if (hold_q == HOLD_CNT_W'(1)) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (br_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hdu_pipe.sv
// Scoreboard bench for hdu_pipe: instance A forwards (LOAD_LAT=3, CNT_W=4), instance B stalls.
module tb_hdu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       id_use_rs2, idex_memRead, idex_regWrite, exmem_regWrite, memwb_regWrite;
  logic       br_taken;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_st, a_fi, a_fx, b_st, b_fi, b_fx;
  logic [3:0]  a_sc, a_fc;
  logic [31:0] b_sc, b_fc;

  always #5 clk = ~clk;

  hdu_pipe #(
    .FORWARDING_ON (1),
    .REG_W         (5),
    .LOAD_LAT      (3),
    .CNT_W         (4)
  ) u_a (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs2     (id_use_rs2),
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .idex_rd        (idex_rd),
    .idex_memRead   (idex_memRead),
    .idex_regWrite  (idex_regWrite),
    .exmem_rd       (exmem_rd),
    .exmem_regWrite (exmem_regWrite),
    .memwb_rd       (memwb_rd),
    .memwb_regWrite (memwb_regWrite),
    .br_taken       (br_taken),
    .forwA          (a_fa),
    .forwB          (a_fb),
    .stall          (a_st),
    .flush_ifid     (a_fi),
    .flush_idex     (a_fx),
    .stall_cnt      (a_sc),
    .flush_cnt      (a_fc)
  );

  hdu_pipe #(
    .FORWARDING_ON (0),
    .REG_W         (5),
    .LOAD_LAT      (1),
    .CNT_W         (32)
  ) u_b (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs2     (id_use_rs2),
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .idex_rd        (idex_rd),
    .idex_memRead   (idex_memRead),
    .idex_regWrite  (idex_regWrite),
    .exmem_rd       (exmem_rd),
    .exmem_regWrite (exmem_regWrite),
    .memwb_rd       (memwb_rd),
    .memwb_regWrite (memwb_regWrite),
    .br_taken       (br_taken),
    .forwA          (b_fa),
    .forwB          (b_fb),
    .stall          (b_st),
    .flush_ifid     (b_fi),
    .flush_idex     (b_fx),
    .stall_cnt      (b_sc),
    .flush_cnt      (b_fc)
  );

  typedef struct {
    string      name;
    logic [1:0] fa, fb;
    logic       st, fi, fx;
    logic [3:0] sc, fc;
    logic       b_en;
    logic [1:0] b_fa, b_fb;
    logic       b_st;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Push the expected response for the current cycle, then move to the next cycle.
  task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic fi, input logic fx,
                     input logic [3:0] sc, input logic [3:0] fc,
                     input logic ben, input logic [1:0] bfa, input logic bst);
    exp_t e;
    e.name = nm; e.fa = fa; e.fb = fb; e.st = st; e.fi = fi; e.fx = fx;
    e.sc = sc; e.fc = fc; e.b_en = ben; e.b_fa = bfa; e.b_fb = 2'b00; e.b_st = bst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_use_rs2 = 1'b0;
    idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0; idex_memRead = 1'b0; idex_regWrite = 1'b0;
    exmem_rd = '0; exmem_regWrite = 1'b0; memwb_rd = '0; memwb_regWrite = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (a_fa !== e.fa || a_fb !== e.fb || a_st !== e.st || a_fi !== e.fi ||
          a_fx !== e.fx || a_sc !== e.sc || a_fc !== e.fc) begin
        $display("FAIL %s (fwd): got forwA=%b forwB=%b stall=%b fl_ifid=%b fl_idex=%b scnt=%0d fcnt=%0d, want %b %b %b %b %b %0d %0d",
                 e.name, a_fa, a_fb, a_st, a_fi, a_fx, a_sc, a_fc,
                 e.fa, e.fb, e.st, e.fi, e.fx, e.sc, e.fc);
      end else begin
        n_pass++;
      end
      if (e.b_en) begin
        n_chk++;
        if (b_fa !== e.b_fa || b_fb !== e.b_fb || b_st !== e.b_st) begin
          $display("FAIL %s (nofwd): got forwA=%b forwB=%b stall=%b, want %b %b %b",
                   e.name, b_fa, b_fb, b_st, e.b_fa, e.b_fb, e.b_st);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_reset", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    rst = 1'b0;
    chk("idle", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);

    // Forwarding selects
    exmem_rd = 5; exmem_regWrite = 1; memwb_rd = 5; memwb_regWrite = 1;
    idex_rs1 = 5; idex_rs2 = 5;
    chk("fwd_exmem_prio", 2'b01, 2'b01, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    exmem_regWrite = 0;
    chk("fwd_memwb_both", 2'b10, 2'b10, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    memwb_rd = 7; idex_rs1 = 3; idex_rs2 = 7;
    chk("fwd_memwb_b", 2'b00, 2'b10, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    exmem_rd = 0; exmem_regWrite = 1; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
    chk("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    exmem_rd = 3; memwb_rd = 7; idex_rs1 = 3; idex_rs2 = 7;
    chk("fwd_indep", 2'b01, 2'b10, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);

    // Stall-only RAW detection
    clr();
    exmem_rd = 9; exmem_regWrite = 1; id_rs1 = 9; idex_rs1 = 9;
    chk("nofwd_exmem_rs1", 2'b01, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 1);
    id_rs1 = 0; id_rs2 = 9;
    chk("nofwd_rs2_unused", 2'b01, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);
    id_use_rs2 = 1;
    chk("nofwd_rs2_used", 2'b01, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 1);
    exmem_regWrite = 0; memwb_rd = 9; memwb_regWrite = 1; id_rs1 = 9; id_use_rs2 = 0;
    chk("nofwd_memwb", 2'b10, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 1);
    memwb_regWrite = 0; idex_rd = 9; idex_regWrite = 1;
    chk("nofwd_idex_alu", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 1);

    // Load-use through rs2 that the ID instruction does not read
    clr();
    idex_memRead = 1; idex_regWrite = 1; idex_rd = 4; id_rs2 = 4;
    chk("load_rs2_unused", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 0);

    // Load-use, LOAD_LAT=3
    rst_pulse();
    id_rs2 = 0; id_rs1 = 4;
    chk("load_c1", 2'b00, 2'b00, 1, 0, 1, 4'd0, 4'd0, 0, 2'b00, 0);
    chk("load_c2", 2'b00, 2'b00, 1, 0, 1, 4'd1, 4'd0, 0, 2'b00, 0);
    chk("load_c3", 2'b00, 2'b00, 1, 0, 1, 4'd2, 4'd0, 0, 2'b00, 0);
    idex_memRead = 0; idex_regWrite = 0; idex_rd = 0;
    chk("load_done", 2'b00, 2'b00, 0, 0, 0, 4'd3, 4'd0, 0, 2'b00, 0);

    // Branch aborts HOLD
    rst_pulse();
    idex_memRead = 1; idex_regWrite = 1; idex_rd = 4; id_rs1 = 4;
    chk("br_c1", 2'b00, 2'b00, 1, 0, 1, 4'd0, 4'd0, 0, 2'b00, 0);
    br_taken = 1;
    chk("br_c2", 2'b00, 2'b00, 0, 1, 1, 4'd1, 4'd0, 0, 2'b00, 0);
    br_taken = 0; idex_memRead = 0; idex_regWrite = 0; idex_rd = 0;
    chk("br_after", 2'b00, 2'b00, 0, 0, 0, 4'd1, 4'd1, 0, 2'b00, 0);

    // Asynchronous reset mid-HOLD
    rst_pulse();
    idex_memRead = 1; idex_regWrite = 1; idex_rd = 4; id_rs1 = 4;
    chk("arst_c1", 2'b00, 2'b00, 1, 0, 1, 4'd0, 4'd0, 0, 2'b00, 0);
    chk("arst_c2", 2'b00, 2'b00, 1, 0, 1, 4'd1, 4'd0, 0, 2'b00, 0);
    rst = 1; idex_memRead = 0; idex_regWrite = 0; idex_rd = 0;
    chk("arst_now", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 0, 2'b00, 0);
    rst = 0;
    chk("arst_after", 2'b00, 2'b00, 0, 0, 0, 4'd0, 4'd0, 0, 2'b00, 0);

    // Stall counter saturation at 15 (CNT_W=4)
    idex_memRead = 1; idex_regWrite = 1; idex_rd = 4; id_rs1 = 4;
    for (int i = 0; i < 21; i++) begin
      chk("sat_stall", 2'b00, 2'b00, 1, 0, 1, (i < 15) ? 4'(i) : 4'd15, 4'd0, 0, 2'b00, 0);
    end
    idex_memRead = 0; idex_regWrite = 0; idex_rd = 0;
    chk("sat_hold", 2'b00, 2'b00, 0, 0, 0, 4'd15, 4'd0, 0, 2'b00, 0);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdu_pipe.md
HDU_PIPE -- requirements
Module: hdu_pipe

Interface
REQ-001 Parameter FORWARDING_ON, default 1; 1 = bypass network enabled, 0 = resolve every RAW hazard by stalling.
REQ-002 Parameter REG_W, default 5; register-index width.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..4; number of stall cycles a load-use hazard costs.
REQ-004 Parameter CNT_W, default 32; width of the performance counters.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 id_rs1, id_rs2  input  REG_W each  source registers of the instruction in ID.
REQ-008 id_use_rs2  input  1  the instruction in ID reads rs2.
REQ-009 idex_rs1, idex_rs2, idex_rd  input  REG_W each  ID/EX register fields.
REQ-010 idex_memRead, idex_regWrite  input  1 each  ID/EX control.
REQ-011 exmem_rd  input  REG_W; exmem_regWrite  input  1.
REQ-012 memwb_rd  input  REG_W; memwb_regWrite  input  1.
REQ-013 br_taken  input  1  taken branch or jump resolved in EX this cycle.
REQ-014 forwA, forwB  output  2 each  operand mux select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-015 stall  output  1  hold PC and IF/ID.
REQ-016 flush_ifid, flush_idex  output  1 each  replace stage contents with a bubble.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-018 forwA and forwB are combinational and evaluated independently for idex_rs1 and idex_rs2: EX/MEM match (regWrite, rd!=0, rd==rs) gives 01 and takes priority over MEM/WB match, which gives 10; otherwise 00.
REQ-019 With FORWARDING_ON=0, forwA and forwB are held at 00.
REQ-020 Hazard hit (FORWARDING_ON=1): idex_memRead and idex_rd!=0 and idex_rd matches id_rs1, or matches id_rs2 with id_use_rs2=1.
REQ-021 Hazard hit (FORWARDING_ON=0): any of ID/EX, EX/MEM or MEM/WB has regWrite=1, rd!=0 and rd matching a used ID source.
REQ-022 FSM states are IDLE, HOLD.
REQ-023 In IDLE with a hit, stall=1 and flush_idex=1 in the same cycle; if LOAD_LAT>1, the block loads remaining-count = LOAD_LAT-1 and enters HOLD.
REQ-024 In HOLD, stall=1 each cycle; the count decrements and the FSM returns to IDLE on the cycle the count reaches 0; it then re-evaluates hits.
REQ-025 In HOLD, flush_idex=1 every cycle, so repeated bubbles are inserted.
REQ-026 br_taken=1 forces flush_ifid=1 and flush_idex=1 and stall=0 that cycle, in any state, and aborts HOLD to IDLE on the next edge; branch beats stall.
REQ-027 stall_cnt increments on every cycle with stall=1.
REQ-028 flush_cnt increments on every cycle with br_taken=1.
REQ-029 Both counters saturate at all-ones and do not wrap.
REQ-030 With no hit and no br_taken, stall, flush_ifid and flush_idex are 0.

Reset
REQ-031 rst=1 immediately forces state IDLE, remaining-count 0, stall_cnt 0 and flush_cnt 0, regardless of clk.
REQ-032 During reset, the registered contributions to stall and flush are 0.
REQ-033 Reset asserted mid-HOLD abandons the hold; no stall carries over after release.

Structure
REQ-034 The FSM state enum and the forward-select constants (FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10) reside in the shared CPU package.
REQ-035 Forward selection is one sub-module, fwd_sel, instantiated once per operand.

Verification
REQ-036 Scenario 1: EX/MEM rd=5 regWrite=1, MEM/WB rd=5 regWrite=1, idex_rs1=5, idex_rs2=5 -> forwA=01, forwB=01.
REQ-037 Scenario 2: MEM/WB rd=7 only, idex_rs2=7, rd of x0 cases -> forwB=10; any match on rd=0 -> 00.
REQ-038 Scenario 3: LOAD_LAT=3, load rd=4 in ID/EX, ID reads x4 -> stall high exactly 3 cycles, flush_idex high 3 cycles, stall_cnt=3.
REQ-039 Scenario 4: LOAD_LAT=3, br_taken in the 2nd stall cycle -> that cycle stall=0 with flush_ifid=flush_idex=1, IDLE next, stall_cnt=1, flush_cnt=1.
REQ-040 Scenario 5: FORWARDING_ON=0, EX/MEM rd=9 and ID rs1=9 -> stall=1, forwA=00.
REQ-041 Scenario 6: rst pulsed asynchronously mid-HOLD -> outputs 0 before the next edge; CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.
